// File: rtl/npu_ctrl_pkg.sv
// Shared types and defaults for the NPU issue controller.
package npu_ctrl_pkg;

    localparam int NPU_DATA_W          = 32;
    localparam int NPU_FUNC_W          = 4;
    localparam int NPU_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } npu_state_e;

endpackage

// File: rtl/npu_issue_ctrl_if.sv
// Request/response channel between the issue controller and the NPU.
interface npu_issue_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int FUNC_W = 4
) ();

    logic              npu_req_valid;
    logic              npu_req_ready;
    logic [FUNC_W-1:0] npu_req_func;
    logic [DATA_W-1:0] npu_req_a;
    logic [DATA_W-1:0] npu_req_b;
    logic              npu_rsp_valid;
    logic [DATA_W-1:0] npu_rsp_data;

    modport master (
        output npu_req_valid, npu_req_func, npu_req_a, npu_req_b,
        input  npu_req_ready, npu_rsp_valid, npu_rsp_data
    );

    modport slave (
        input  npu_req_valid, npu_req_func, npu_req_a, npu_req_b,
        output npu_req_ready, npu_rsp_valid, npu_rsp_data
    );

endinterface

// File: rtl/npu_timeout_counter.sv
// Saturating wait counter; tc is high once the count has reached TIMEOUT.
module npu_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int                CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != TC_VAL)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/npu_issue_ctrl.sv
// EX-stage sequencer: latches an NPU op, issues it, stalls until the result
// returns, and absorbs flushes and timeouts so the core never wedges.
module npu_issue_ctrl
    import npu_ctrl_pkg::*;
#(
    parameter int DATA_W  = NPU_DATA_W,
    parameter int FUNC_W  = NPU_FUNC_W,
    parameter int TIMEOUT = NPU_TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ex_valid,
    input  logic                 ex_en_npu,
    input  logic [FUNC_W-1:0]    ex_func,
    input  logic [DATA_W-1:0]    ex_op_a,
    input  logic [DATA_W-1:0]    ex_op_b,
    input  logic                 flush,
    npu_issue_ctrl_if.master     npu,
    output logic                 npu_stall,
    output logic [DATA_W-1:0]    npu_result,
    output logic                 npu_result_valid,
    output logic                 npu_timeout,
    output logic                 busy
);

    npu_state_e        state_q, state_d;
    logic              kill_q, kill_d;
    logic [FUNC_W-1:0] func_q, func_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0] result_q, result_d;

    logic start, kill_now, cnt_clear, cnt_en, cnt_tc;

    assign start    = ex_valid & ex_en_npu & ~flush;
    // A flush landing on the completing cycle still squashes the result.
    assign kill_now = kill_q | flush;

    npu_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .tc     (cnt_tc)
    );

    // NOTE: synchronous reset clears state, kill flag and every payload latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            kill_q   <= 1'b0;
            func_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            kill_q   <= kill_d;
            func_q   <= func_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        kill_d    = kill_q;
        func_d    = func_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    func_d  = ex_func;
                    a_d     = ex_op_a;
                    b_d     = ex_op_b;
                    kill_d  = 1'b0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (flush) kill_d = 1'b1;
                if (npu.npu_req_ready) begin
                    cnt_clear = 1'b1;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_en = 1'b1;
                if (flush) kill_d = 1'b1;
                // The response has priority over a timeout in the same cycle.
                if (npu.npu_rsp_valid) begin
                    result_d = npu.npu_rsp_data;
                    state_d  = kill_now ? ST_IDLE : ST_DONE;
                end else if (cnt_tc) begin
                    result_d = '0;
                    state_d  = kill_now ? ST_IDLE : ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy              = (state_q != ST_IDLE);
        npu.npu_req_valid = (state_q == ST_ISSUE);
        npu.npu_req_func  = func_q;
        npu.npu_req_a     = a_q;
        npu.npu_req_b     = b_q;
        npu_result        = result_q;
        npu_result_valid  = (state_q == ST_DONE) & ~flush;
        npu_timeout       = (state_q == ST_WAIT) & cnt_tc & ~npu.npu_rsp_valid;
        // Last term holds a new NPU op in EX while a killed op drains.
        npu_stall = ((state_q == ST_IDLE) & start)
                  | (((state_q == ST_ISSUE) | (state_q == ST_WAIT)) & ~kill_q)
                  | (busy & ex_valid & ex_en_npu & kill_q);
    end

endmodule

// File: tb/tb_npu_issue_ctrl.sv
// Self-checking bench: per-op cycle schedule derived from the op's ready and
// response delays, compared cycle by cycle against the controller outputs.
module tb_npu_issue_ctrl;

    localparam int DW = 32;
    localparam int FW = 4;
    localparam int TO = 255;

    logic          clk = 1'b0;
    logic          reset;
    logic          ex_valid, ex_en_npu, flush;
    logic [FW-1:0] ex_func;
    logic [DW-1:0] ex_op_a, ex_op_b;
    logic          npu_stall, npu_result_valid, npu_timeout, busy;
    logic [DW-1:0] npu_result;

    int checks = 0;
    int errors = 0;

    npu_issue_ctrl_if #(.DATA_W(DW), .FUNC_W(FW)) npu_bus ();

    npu_issue_ctrl #(.DATA_W(DW), .FUNC_W(FW), .TIMEOUT(TO)) dut (
        .clk              (clk),
        .reset            (reset),
        .ex_valid         (ex_valid),
        .ex_en_npu        (ex_en_npu),
        .ex_func          (ex_func),
        .ex_op_a          (ex_op_a),
        .ex_op_b          (ex_op_b),
        .flush            (flush),
        .npu              (npu_bus),
        .npu_stall        (npu_stall),
        .npu_result       (npu_result),
        .npu_result_valid (npu_result_valid),
        .npu_timeout      (npu_timeout),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // All outputs, including latched payload and result, must read zero.
    task automatic expect_cleared(input string tag);
        checks++;
        if ({npu_bus.npu_req_valid, npu_stall, npu_result_valid, npu_timeout, busy} !== 5'b0) begin
            errors++;
            $display("FAIL %s_ctrl got %b exp 00000", tag,
                     {npu_bus.npu_req_valid, npu_stall, npu_result_valid, npu_timeout, busy});
        end
        checks++;
        if ({npu_bus.npu_req_func, npu_bus.npu_req_a, npu_bus.npu_req_b, npu_result} !== '0) begin
            errors++;
            $display("FAIL %s_data got %h/%h/%h/%h exp 0", tag, npu_bus.npu_req_func,
                     npu_bus.npu_req_a, npu_bus.npu_req_b, npu_result);
        end
    endtask

    task automatic idle_cycle();
        ex_valid = 1'b0; ex_en_npu = $urandom_range(0, 1); flush = 1'b0;
        npu_bus.npu_req_ready = $urandom_range(0, 1);
        npu_bus.npu_rsp_valid = 1'b0;
        #2;
        checks++;
        if ({npu_stall, busy, npu_bus.npu_req_valid, npu_result_valid} !== 4'b0) begin
            errors++;
            $display("FAIL idle got %b exp 0000",
                     {npu_stall, busy, npu_bus.npu_req_valid, npu_result_valid});
        end
        tick();
    endtask

    // One NPU op starting in IDLE at k=0. Ready rises dr cycles after ISSUE is
    // entered; the response comes rd cycles after WAIT entry (rd<0: never).
    task automatic run_op(input logic [FW-1:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] data, input int dr, input int rd, input bit flush_done);
        int acc, w, r, d, t_out, xfers;
        bit timed_out;
        logic exp_rv, exp_stall, exp_res_v, exp_to, exp_busy;
        logic [DW-1:0] exp_res;
        acc       = 1 + dr;
        w         = acc + 1;
        timed_out = (rd < 0) || (rd > TO);
        r         = timed_out ? -1 : w + rd;
        d         = timed_out ? w + TO + 1 : r + 1;
        t_out     = timed_out ? w + TO : -1;
        exp_res   = timed_out ? '0 : data;
        xfers     = 0;
        for (int k = 0; k <= d; k++) begin
            ex_valid  = 1'b1;
            ex_en_npu = 1'b1;
            flush     = flush_done && (k == d);
            ex_func   = (k == 0) ? f : FW'($urandom);
            ex_op_a   = (k == 0) ? a : $urandom;
            ex_op_b   = (k == 0) ? b : $urandom;
            npu_bus.npu_req_ready = (k >= acc);
            npu_bus.npu_rsp_valid = (k == r);
            npu_bus.npu_rsp_data  = (k == r) ? data : $urandom;
            #2;
            exp_rv    = (k >= 1) && (k <= acc);
            exp_stall = (k < d);
            exp_res_v = (k == d) && !flush_done;
            exp_to    = (k == t_out);
            exp_busy  = (k >= 1);
            checks++;
            if (npu_bus.npu_req_valid !== exp_rv) begin
                errors++;
                $display("FAIL req_valid k=%0d got %b exp %b", k, npu_bus.npu_req_valid, exp_rv);
            end
            checks++;
            if (npu_stall !== exp_stall) begin
                errors++;
                $display("FAIL stall k=%0d got %b exp %b", k, npu_stall, exp_stall);
            end
            checks++;
            if (npu_result_valid !== exp_res_v) begin
                errors++;
                $display("FAIL result_valid k=%0d got %b exp %b", k, npu_result_valid, exp_res_v);
            end
            checks++;
            if (npu_timeout !== exp_to) begin
                errors++;
                $display("FAIL timeout k=%0d got %b exp %b", k, npu_timeout, exp_to);
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL busy k=%0d got %b exp %b", k, busy, exp_busy);
            end
            if (exp_rv) begin
                checks++;
                if ({npu_bus.npu_req_func, npu_bus.npu_req_a, npu_bus.npu_req_b} !== {f, a, b}) begin
                    errors++;
                    $display("FAIL payload k=%0d got %h/%h/%h exp %h/%h/%h", k, npu_bus.npu_req_func,
                             npu_bus.npu_req_a, npu_bus.npu_req_b, f, a, b);
                end
            end
            if (exp_res_v) begin
                checks++;
                if (npu_result !== exp_res) begin
                    errors++;
                    $display("FAIL result got %h exp %h", npu_result, exp_res);
                end
            end
            if (npu_bus.npu_req_valid === 1'b1 && npu_bus.npu_req_ready === 1'b1) xfers++;
            tick();
        end
        checks++;
        if (xfers != 1) begin
            errors++;
            $display("FAIL transfers got %0d exp 1", xfers);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; ex_valid = 1'b0; ex_en_npu = 1'b0; flush = 1'b0;
        ex_func = '0; ex_op_a = '0; ex_op_b = '0;
        npu_bus.npu_req_ready = 1'b0; npu_bus.npu_rsp_valid = 1'b0; npu_bus.npu_rsp_data = '0;
        repeat (3) tick();
        expect_cleared("reset_held");
        reset = 1'b0;
        #2;
        expect_cleared("reset_release");
        tick();
    endtask

    task automatic test_basic();
        run_op(4'h3, 32'd5, 32'd7, 32'h0000_00AB, 0, 0, 1'b0);
        idle_cycle();
    endtask

    task automatic test_backpressure();
        run_op(FW'($urandom), $urandom, $urandom, $urandom, 4, $urandom_range(0, 3), 1'b0);
        idle_cycle();
    endtask

    // Flush mid-WAIT, one bubble, then a new NPU op sits in EX while the
    // killed op drains; the new op then starts normally from IDLE.
    task automatic test_flush_wait();
        int fd, f_cyc, r;
        logic [FW-1:0] nf;
        logic [DW-1:0] na, nb;
        logic exp_stall;
        fd = $urandom_range(0, 3);
        f_cyc = 2 + fd;
        r = f_cyc + 5;
        nf = FW'($urandom); na = $urandom; nb = $urandom;
        for (int k = 0; k <= r; k++) begin
            ex_valid  = (k != f_cyc + 1);
            ex_en_npu = 1'b1;
            flush     = (k == f_cyc);
            ex_func   = (k >= f_cyc + 2) ? nf : FW'($urandom);
            ex_op_a   = (k >= f_cyc + 2) ? na : $urandom;
            ex_op_b   = (k >= f_cyc + 2) ? nb : $urandom;
            npu_bus.npu_req_ready = (k >= 1);
            npu_bus.npu_rsp_valid = (k == r);
            npu_bus.npu_rsp_data  = $urandom;
            #2;
            exp_stall = (k != f_cyc + 1);
            checks++;
            if (npu_stall !== exp_stall) begin
                errors++;
                $display("FAIL flush_stall k=%0d got %b exp %b", k, npu_stall, exp_stall);
            end
            checks++;
            if (npu_result_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_result_valid k=%0d got %b exp 0", k, npu_result_valid);
            end
            checks++;
            if (busy !== (k >= 1)) begin
                errors++;
                $display("FAIL flush_busy k=%0d got %b exp %b", k, busy, (k >= 1));
            end
            tick();
        end
        run_op(nf, na, nb, $urandom, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
        idle_cycle();
    endtask

    task automatic test_flush_done();
        run_op(FW'($urandom), $urandom, $urandom, $urandom, 1, 2, 1'b1);
        idle_cycle();
    endtask

    task automatic test_timeout();
        run_op(FW'($urandom), $urandom, $urandom, $urandom, 0, -1, 1'b0);
        idle_cycle();
        run_op(FW'($urandom), $urandom, $urandom, $urandom, 1, TO, 1'b0);
        idle_cycle();
    endtask

    task automatic test_reset_mid(input bit in_wait);
        int kr;
        kr = in_wait ? 3 : 1;
        for (int k = 0; k <= kr; k++) begin
            ex_valid = 1'b1; ex_en_npu = 1'b1; flush = 1'b0;
            ex_func = FW'($urandom) | 4'h1; ex_op_a = $urandom | 32'h1; ex_op_b = $urandom | 32'h1;
            npu_bus.npu_req_ready = in_wait && (k >= 1);
            npu_bus.npu_rsp_valid = 1'b0;
            reset = (k == kr);
            tick();
        end
        reset = 1'b0; ex_valid = 1'b0; npu_bus.npu_req_ready = 1'b0;
        #2;
        expect_cleared(in_wait ? "reset_wait" : "reset_issue");
        tick();
        run_op(FW'($urandom), $urandom, $urandom, $urandom, 0, 1, 1'b0);
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        run_op(4'h1, 32'h11, 32'h22, 32'hCAFE_0001, 0, 0, 1'b0);
        run_op(4'h2, 32'h33, 32'h44, 32'hCAFE_0002, 0, 0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            run_op(FW'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, 5),
                   $urandom_range(0, 8), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_flush_wait();
        test_flush_done();
        test_timeout();
        test_reset_mid(1'b0);
        test_reset_mid(1'b1);
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
